// File: rtl/mbadd_seq_pkg.sv
// mbadd_seq_pkg: shared op/state encodings for the multi-byte add/subtract sequencer.
package mbadd_seq_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  // Subtraction is A + ~B + 1, so SUB seeds 1 and SBB seeds the inverted borrow.
  function automatic logic start_carry(input logic [1:0] op, input logic cin);
    return op[1] ^ (op[0] & cin);
  endfunction
endpackage

// File: rtl/mbadd_seq_add8b.sv
// add8b: ripple byte adder exposing every bit carry (oC[MSB] is carry out) and result parity.
module add8b #(
  parameter int DATASIZE = 8
) (
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic                iC,
  output logic [DATASIZE-1:0] oS,
  output logic [DATASIZE-1:0] oC,
  output logic                oP
);
  logic c;
  always_comb begin
    c = iC;
    oS = '0;
    oC = '0;
    for (int i = 0; i < DATASIZE; i++) begin
      oS[i] = iA[i] ^ iB[i] ^ c;
      oC[i] = (iA[i] & iB[i]) | (c & (iA[i] ^ iB[i]));
      c = oC[i];
    end
    oP = ^oS;
  end
endmodule

// File: rtl/mbadd_seq.sv
// mbadd_seq: NBYTES-wide add/subtract done one byte per clock, LSB first, on one shared add8b.
// Define MBADD_OVF_EN to add the signed-overflow output flag_v.
module mbadd_seq
  import mbadd_seq_pkg::*;
#(
  parameter int NBYTES = 2,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         cin,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res,
  output logic         flag_c,
`ifdef MBADD_OVF_EN
  output logic         flag_v,
`endif
  output logic         flag_z
);
  logic [0:0]   state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic         cy_q, cy_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic         fc_q, fc_d, fz_q, fz_d, done_q, done_d;
  logic [7:0]   a_byte, b_byte, sum, add_c;
  logic         par, sub, last;
  assign sub = op_q[1];
  assign last = idx_q == 3'(NBYTES - 1);
  assign a_byte = a_q[8*idx_q +: 8];
  assign b_byte = b_q[8*idx_q +: 8] ^ {8{sub}};
  add8b #(.DATASIZE(8)) u_add (
    .iA(a_byte),
    .iB(b_byte),
    .iC(cy_q),
    .oS(sum),
    .oC(add_c),
    .oP(par)
  );
  logic unused_ok;
  assign unused_ok = ^{add_c[6:0], par};
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cy_d = cy_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    fc_d = fc_q;
    fz_d = fz_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_RUN;
        idx_d = '0;
        cy_d = start_carry(op, cin);
        op_d = op;
        a_d = opa;
        b_d = opb;
      end
    end else begin
      res_d[8*idx_q +: 8] = sum;
      cy_d = add_c[7];
      idx_d = idx_q + 3'd1;
      if (last) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
        fc_d = add_c[7] ^ sub;
        fz_d = res_d == '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      cy_q <= 1'b0;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      fc_q <= 1'b0;
      fz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cy_q <= cy_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      fc_q <= fc_d;
      fz_q <= fz_d;
      done_q <= done_d;
    end
`ifdef MBADD_OVF_EN
  logic v_q, v_d;
  // Same-sign operands (B as actually added) producing a different result sign.
  assign v_d = (a_q[W-1] == (b_q[W-1] ^ sub)) & (sum[7] != a_q[W-1]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v_q <= 1'b0;
    else if (state_q == ST_RUN && last) v_q <= v_d;
  assign flag_v = v_q;
`endif
  assign busy = state_q == ST_RUN;
  assign done = done_q;
  assign res = res_q;
  assign flag_c = fc_q;
  assign flag_z = fz_q;
endmodule

// File: tb/tb_mbadd_seq.sv
// tb_mbadd_seq: directed vector table plus hand sequences for busy/done/reset corners of mbadd_seq.
module tb_mbadd_seq;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] opa = '0, opb = '0;
  logic busy, done, flag_c, flag_z;
  logic [W-1:0] res;
`ifdef MBADD_OVF_EN
  logic flag_v;
`endif
  mbadd_seq #(.NBYTES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .cin(cin),
    .opa(opa),
    .opb(opb),
    .busy(busy),
    .done(done),
    .res(res),
    .flag_c(flag_c),
`ifdef MBADD_OVF_EN
    .flag_v(flag_v),
`endif
    .flag_z(flag_z)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  op;
    logic        cin;
    logic [15:0] a, b, r;
    logic        c, z, v;
  } vec_t;
  vec_t vt[13];
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic ci, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o;
    cin = ci;
    opa = a;
    opb = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    vt[0]  = '{2'b00, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{2'b00, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{2'b01, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{2'b10, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{2'b10, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{2'b11, 1'b1, 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{2'b00, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{2'b10, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{2'b01, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{2'b11, 1'b0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vt[10] = '{2'b10, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[11] = '{2'b00, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vt[12] = '{2'b10, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_c", 32'(flag_c), 32'd0);
    chk("rst_z", 32'(flag_z), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      issue(vt[i].op, vt[i].cin, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_early_done", i), 32'(done), 32'd0);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'd2);
      chk($sformatf("v%0d_res", i), 32'(res), 32'(vt[i].r));
      chk($sformatf("v%0d_c", i), 32'(flag_c), 32'(vt[i].c));
      chk($sformatf("v%0d_z", i), 32'(flag_z), 32'(vt[i].z));
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
`ifdef MBADD_OVF_EN
      chk($sformatf("v%0d_v", i), 32'(flag_v), 32'(vt[i].v));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
    end
    // start while busy must not relatch operands
    issue(2'b00, 1'b0, 16'h1234, 16'h4321);
    op = 2'b10;
    opa = 16'hFFFF;
    opb = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", 32'(n), 32'd1);
    chk("ign_res", 32'(res), 32'h5555);
    chk("ign_c", 32'(flag_c), 32'd0);
    @(negedge clk);
    chk("ign_idle", 32'(busy), 32'd0);
    chk("ign_pulse", 32'(done), 32'd0);
    // start raised in the done cycle is accepted
    issue(2'b00, 1'b0, 16'h0001, 16'h0001);
    wait_done(n);
    chk("dc_first_done", 32'(done), 32'd1);
    op = 2'b00;
    opa = 16'h00F0;
    opb = 16'h0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dc_busy", 32'(busy), 32'd1);
    chk("dc_done_once", 32'(done), 32'd0);
    chk("dc_res_held", 32'(res), 32'h0002);
    wait_done(n);
    chk("dc_latency", 32'(n), 32'd2);
    chk("dc_res", 32'(res), 32'h0100);
    chk("dc_c", 32'(flag_c), 32'd0);
    // reset during the first RUN cycle
    issue(2'b00, 1'b0, 16'h1111, 16'h2222);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_res", 32'(res), 32'd0);
    chk("ar_c", 32'(flag_c), 32'd0);
    chk("ar_z", 32'(flag_z), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ar_nodone%0d", i), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    issue(2'b10, 1'b0, 16'h0100, 16'h0001);
    wait_done(n);
    chk("ar_latency", 32'(n), 32'd2);
    chk("ar_res_after", 32'(res), 32'h00FF);
    chk("ar_c_after", 32'(flag_c), 32'd0);
    chk("ar_z_after", 32'(flag_z), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
